// File: rtl/spu_issue_unit_if.sv
// Fetch-to-issue channel carrying one predecoded, fetch-aligned instruction pair.
interface spu_issue_unit_if #(
  parameter int WORD   = 32,
  parameter int DESC_W = 69
);
  // Handshake: a pair transfers on a rising edge where ins_valid && ins_ready.
  // The master holds ins_pc/ins0_desc/ins1_desc/ins1_valid stable while
  // ins_valid is high and not yet accepted; ins_ready never depends on ins_valid.
  logic              ins_valid;
  logic              ins_ready;
  logic [WORD-1:0]   ins_pc;
  logic [DESC_W-1:0] ins0_desc;
  logic [DESC_W-1:0] ins1_desc;
  logic              ins1_valid;

  modport master (output ins_valid, ins_pc, ins0_desc, ins1_desc, ins1_valid,
                  input  ins_ready);
  modport slave  (input  ins_valid, ins_pc, ins0_desc, ins1_desc, ins1_valid,
                  output ins_ready);
endinterface

// File: rtl/spu_issue_unit.sv
// Dual-issue stage: one-pair buffer, even/odd pipe routing, latency scoreboard
// for RAW/WAW stalls, and flush on odd-pipe branch redirect.
module spu_issue_unit #(
  parameter int WORD                 = 32,
  parameter int UNIT_ID_SIZE         = 3,
  parameter int INTERNAL_OPCODE_SIZE = 11,
  parameter int REG_ADDR_WIDTH       = 7,
  parameter int IMM18                = 18,
  parameter int DESC_W = 2 + 4 + UNIT_ID_SIZE + INTERNAL_OPCODE_SIZE + 3 + 4 * REG_ADDR_WIDTH + IMM18,
  parameter logic [INTERNAL_OPCODE_SIZE-1:0] NOP_EVEN = '0,
  parameter logic [INTERNAL_OPCODE_SIZE-1:0] NOP_ODD  = '0
) (
  input  logic                            clk,
  input  logic                            reset,
  spu_issue_unit_if.slave                 ins,
  input  logic                            branch_taken,
  input  logic [WORD-1:0]                 PC_out,
  output logic                            redirect_valid,
  output logic [WORD-1:0]                 redirect_pc,
  output logic [UNIT_ID_SIZE-1:0]         rf_unit_id,
  output logic [INTERNAL_OPCODE_SIZE-1:0] rf_opcode_even,
  output logic [INTERNAL_OPCODE_SIZE-1:0] rf_opcode_odd,
  output logic [REG_ADDR_WIDTH-1:0]       addr_ra_rd_even,
  output logic [REG_ADDR_WIDTH-1:0]       addr_ra_rd_odd,
  output logic [REG_ADDR_WIDTH-1:0]       addr_rb_rd_even,
  output logic [REG_ADDR_WIDTH-1:0]       addr_rb_rd_odd,
  output logic [REG_ADDR_WIDTH-1:0]       addr_rc_rd_even,
  output logic [REG_ADDR_WIDTH-1:0]       addr_rc_rd_odd,
  output logic [REG_ADDR_WIDTH-1:0]       rf_addr_rt_wt_even,
  output logic [REG_ADDR_WIDTH-1:0]       rf_addr_rt_wt_odd,
  output logic [6:0]                      rf_imm7_even,
  output logic [6:0]                      rf_imm7_odd,
  output logic [9:0]                      rf_imm10_even,
  output logic [9:0]                      rf_imm10_odd,
  output logic [15:0]                     rf_imm16_odd,
  output logic [IMM18-1:0]                rf_imm18_odd,
  output logic [WORD-1:0]                 PC,
  output logic                            stall,
  output logic [1:0]                      dbg_state
);
  localparam int NREG = 1 << REG_ADDR_WIDTH;

  typedef struct packed {
    logic                            pipe;
    logic                            wr;
    logic [3:0]                      lat;
    logic [UNIT_ID_SIZE-1:0]         unit_id;
    logic [INTERNAL_OPCODE_SIZE-1:0] opcode;
    logic                            use_ra, use_rb, use_rc;
    logic [REG_ADDR_WIDTH-1:0]       ra, rb, rc, rt;
    logic [IMM18-1:0]                imm18;
  } desc_t;

  typedef struct packed {
    logic [UNIT_ID_SIZE-1:0]         unit_id;
    logic [INTERNAL_OPCODE_SIZE-1:0] op_e, op_o;
    logic [REG_ADDR_WIDTH-1:0]       ra_e, rb_e, rc_e, rt_e, ra_o, rb_o, rc_o, rt_o;
    logic [9:0]                      imm10_e;
    logic [IMM18-1:0]                imm18_o;
    logic [WORD-1:0]                 pc_o;
    logic                            stall;
    logic                            redir_v;
    logic [WORD-1:0]                 redir_pc;
  } out_t;

  // PAIR: slot 0 pending (slot 1 too when pend1). ONE: only slot 1 pending.
  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_PAIR = 2'd1, S_ONE = 2'd2} state_t;

  state_t          state_q, state_d;
  desc_t           d0_q, d0_d, d1_q, d1_d;
  logic [WORD-1:0] pc_q, pc_d;
  logic            pend1_q, pend1_d;
  logic [2:0]      sb_q [NREG];
  logic [2:0]      sb_d [NREG];
  out_t            out_q, out_d;

  logic [NREG-1:0] busy;
  desc_t           head;
  logic [WORD-1:0] head_pc, pc1;
  logic            issue_head, issue_second, pair_ok, all_issued, accept;

  function automatic logic hazard(desc_t d, logic [NREG-1:0] b);
    return (d.use_ra && b[d.ra]) || (d.use_rb && b[d.rb]) ||
           (d.use_rc && b[d.rc]) || (d.wr && b[d.rt]);
  endfunction

  function automatic logic reads(desc_t d, logic [REG_ADDR_WIDTH-1:0] r);
    return (d.use_ra && d.ra == r) || (d.use_rb && d.rb == r) || (d.use_rc && d.rc == r);
  endfunction

  // lat is 2..7 by construction; larger values clamp to the counter maximum.
  function automatic logic [2:0] lat3(logic [3:0] lat);
    return lat[3] ? 3'd7 : lat[2:0];
  endfunction

  function automatic out_t route(out_t o, desc_t d, logic [WORD-1:0] pc);
    out_t r = o;
    r.unit_id = d.unit_id;
    if (d.pipe) begin
      r.op_o = d.opcode; r.ra_o = d.ra; r.rb_o = d.rb; r.rc_o = d.rc; r.rt_o = d.rt;
      r.imm18_o = d.imm18; r.pc_o = pc;
    end else begin
      r.op_e = d.opcode; r.ra_e = d.ra; r.rb_e = d.rb; r.rc_e = d.rc; r.rt_e = d.rt;
      r.imm10_e = d.imm18[9:0];
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < NREG; i++) busy[i] = (sb_q[i] != 3'd0);
  end

  assign pc1          = pc_q + WORD'(4);
  assign head         = (state_q == S_ONE) ? d1_q : d0_q;
  assign head_pc      = (state_q == S_ONE) ? pc1 : pc_q;
  assign issue_head   = (state_q != S_EMPTY) && !hazard(head, busy) && !branch_taken;
  assign pair_ok      = (d0_q.pipe != d1_q.pipe) && !hazard(d1_q, busy) &&
                        !(d0_q.wr && reads(d1_q, d0_q.rt)) &&
                        !(d0_q.wr && d1_q.wr && d0_q.rt == d1_q.rt);
  assign issue_second = issue_head && (state_q == S_PAIR) && pend1_q && pair_ok;
  assign all_issued   = issue_head && (state_q == S_ONE || !pend1_q || issue_second);
  assign ins.ins_ready = !branch_taken && (state_q == S_EMPTY || all_issued);
  assign accept       = ins.ins_valid && ins.ins_ready;

  always_comb begin
    state_d = state_q;
    pend1_d = pend1_q;
    d0_d    = d0_q;
    d1_d    = d1_q;
    pc_d    = pc_q;
    if (branch_taken) begin
      state_d = S_EMPTY;
    end else if (accept) begin
      state_d = S_PAIR;
      pend1_d = ins.ins1_valid;
      d0_d    = ins.ins0_desc;
      d1_d    = ins.ins1_desc;
      pc_d    = ins.ins_pc;
    end else if (all_issued) begin
      state_d = S_EMPTY;
    end else if (issue_head && state_q == S_PAIR) begin
      state_d = S_ONE;
    end
  end

  // Odd routes go first so an issuing even instruction owns rf_unit_id.
  always_comb begin
    out_d          = '0;
    out_d.op_e     = NOP_EVEN;
    out_d.op_o     = NOP_ODD;
    out_d.stall    = (state_q != S_EMPTY) && !issue_head;
    out_d.redir_v  = branch_taken;
    out_d.redir_pc = branch_taken ? PC_out : '0;
    if (issue_head && head.pipe)    out_d = route(out_d, head, head_pc);
    if (issue_second && d1_q.pipe)  out_d = route(out_d, d1_q, pc1);
    if (issue_head && !head.pipe)   out_d = route(out_d, head, head_pc);
    if (issue_second && !d1_q.pipe) out_d = route(out_d, d1_q, pc1);
  end

  // A fresh latency overrides the per-cycle decrement of the same register.
  always_comb begin
    for (int i = 0; i < NREG; i++) sb_d[i] = (sb_q[i] != 3'd0) ? sb_q[i] - 3'd1 : 3'd0;
    if (issue_head && head.wr)    sb_d[head.rt] = lat3(head.lat);
    if (issue_second && d1_q.wr)  sb_d[d1_q.rt] = lat3(d1_q.lat);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_EMPTY;
      pend1_q    <= 1'b0;
      d0_q       <= '0;
      d1_q       <= '0;
      pc_q       <= '0;
      out_q      <= '0;
      out_q.op_e <= NOP_EVEN;
      out_q.op_o <= NOP_ODD;
      for (int i = 0; i < NREG; i++) sb_q[i] <= 3'd0;
    end else begin
      state_q <= state_d;
      pend1_q <= pend1_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      for (int i = 0; i < NREG; i++) sb_q[i] <= sb_d[i];
    end
  end

  assign redirect_valid     = out_q.redir_v;
  assign redirect_pc        = out_q.redir_pc;
  assign rf_unit_id         = out_q.unit_id;
  assign rf_opcode_even     = out_q.op_e;
  assign rf_opcode_odd      = out_q.op_o;
  assign addr_ra_rd_even    = out_q.ra_e;
  assign addr_rb_rd_even    = out_q.rb_e;
  assign addr_rc_rd_even    = out_q.rc_e;
  assign rf_addr_rt_wt_even = out_q.rt_e;
  assign addr_ra_rd_odd     = out_q.ra_o;
  assign addr_rb_rd_odd     = out_q.rb_o;
  assign addr_rc_rd_odd     = out_q.rc_o;
  assign rf_addr_rt_wt_odd  = out_q.rt_o;
  assign rf_imm7_even       = out_q.imm10_e[6:0];
  assign rf_imm10_even      = out_q.imm10_e;
  assign rf_imm7_odd        = out_q.imm18_o[6:0];
  assign rf_imm10_odd       = out_q.imm18_o[9:0];
  assign rf_imm16_odd       = out_q.imm18_o[15:0];
  assign rf_imm18_odd       = out_q.imm18_o;
  assign PC                 = out_q.pc_o;
  assign stall              = out_q.stall;
  assign dbg_state          = state_q;
endmodule

// File: tb/tb_spu_issue_unit.sv
// Directed and randomized checks of spu_issue_unit against a queue-based issue model.
module tb_spu_issue_unit;
  localparam logic [10:0] NOP_E = 11'h001;
  localparam logic [10:0] NOP_O = 11'h002;

  typedef struct {
    int pipe, wr, lat, uid, opc, ura, urb, urc, ra, rb, rc, rt, imm;
  } ins_t;
  typedef struct {
    ins_t        i;
    logic [31:0] pc;
  } pend_t;

  logic clk, reset, branch_taken, redirect_valid, stall;
  logic [31:0] PC_out, redirect_pc, PC;
  logic [2:0]  rf_unit_id;
  logic [10:0] rf_opcode_even, rf_opcode_odd;
  logic [6:0]  ra_e, ra_o, rb_e, rb_o, rc_e, rc_o, rt_e, rt_o;
  logic [6:0]  imm7_e, imm7_o;
  logic [9:0]  imm10_e, imm10_o;
  logic [15:0] imm16_o;
  logic [17:0] imm18_o;
  logic [1:0]  dbg_state;

  spu_issue_unit_if #(.WORD(32), .DESC_W(69)) ifc ();

  spu_issue_unit #(.NOP_EVEN(NOP_E), .NOP_ODD(NOP_O)) dut (
    .clk(clk), .reset(reset), .ins(ifc), .branch_taken(branch_taken), .PC_out(PC_out),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .rf_unit_id(rf_unit_id),
    .rf_opcode_even(rf_opcode_even), .rf_opcode_odd(rf_opcode_odd),
    .addr_ra_rd_even(ra_e), .addr_ra_rd_odd(ra_o), .addr_rb_rd_even(rb_e), .addr_rb_rd_odd(rb_o),
    .addr_rc_rd_even(rc_e), .addr_rc_rd_odd(rc_o),
    .rf_addr_rt_wt_even(rt_e), .rf_addr_rt_wt_odd(rt_o),
    .rf_imm7_even(imm7_e), .rf_imm7_odd(imm7_o), .rf_imm10_even(imm10_e), .rf_imm10_odd(imm10_o),
    .rf_imm16_odd(imm16_o), .rf_imm18_odd(imm18_o), .PC(PC), .stall(stall), .dbg_state(dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;
  pend_t pq[$];
  int sb[128];
  ins_t cur_a, cur_b;
  logic cur_v1;
  logic [31:0] cur_pc;
  logic last_acc;
  int ready_low, stall_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [68:0] enc(ins_t x);
    logic [68:0] v;
    v = {x.pipe[0], x.wr[0], x.lat[3:0], x.uid[2:0], x.opc[10:0], x.ura[0], x.urb[0], x.urc[0],
         x.ra[6:0], x.rb[6:0], x.rc[6:0], x.rt[6:0], x.imm[17:0]};
    return v;
  endfunction

  function automatic ins_t rnd_ins();
    ins_t x;
    x.pipe = $urandom_range(0, 1);  x.wr  = $urandom_range(0, 1);
    x.lat  = $urandom_range(2, 7);  x.uid = $urandom_range(0, 7);
    x.opc  = $urandom_range(0, 2047);
    x.ura  = $urandom_range(0, 1);  x.urb = $urandom_range(0, 1);  x.urc = $urandom_range(0, 1);
    x.ra   = $urandom_range(0, 7);  x.rb  = $urandom_range(0, 7);
    x.rc   = $urandom_range(0, 7);  x.rt  = $urandom_range(0, 7);
    x.imm  = $urandom_range(0, 262143);
    return x;
  endfunction

  function automatic ins_t mk(int pipe, int wr, int lat, int rt, int ura, int ra);
    ins_t x = rnd_ins();
    x.pipe = pipe; x.wr = wr; x.lat = lat; x.rt = rt;
    x.ura = ura; x.ra = ra; x.urb = 0; x.urc = 0;
    return x;
  endfunction

  // An instruction waits while any register it reads or writes is still in flight.
  function automatic bit blocked(ins_t x);
    return (x.ura != 0 && sb[x.ra] != 0) || (x.urb != 0 && sb[x.rb] != 0) ||
           (x.urc != 0 && sb[x.rc] != 0) || (x.wr != 0 && sb[x.rt] != 0);
  endfunction

  function automatic bit depends(ins_t y, ins_t o);
    if (o.wr == 0) return 0;
    return (y.ura != 0 && y.ra == o.rt) || (y.urb != 0 && y.rb == o.rt) ||
           (y.urc != 0 && y.rc == o.rt) || (y.wr != 0 && y.rt == o.rt);
  endfunction

  task automatic cycle();
    int n_iss;
    logic exp_ready, acc, has_e, has_o, e_stall, e_rv;
    ins_t x;
    logic [10:0] e_ope, e_opo;
    logic [6:0]  e_rae, e_rbe, e_rce, e_rte, e_rao, e_rbo, e_rco, e_rto;
    logic [17:0] e_imme, e_immo;
    logic [2:0]  uid_e, uid_o, e_uid;
    logic [31:0] e_pc, e_rpc;
    pend_t p;
    #2;
    n_iss = 0;
    if (!branch_taken && pq.size() > 0 && !blocked(pq[0].i)) begin
      n_iss = 1;
      if (pq.size() > 1 && pq[1].i.pipe != pq[0].i.pipe && !blocked(pq[1].i) &&
          !depends(pq[1].i, pq[0].i)) n_iss = 2;
    end
    exp_ready = !branch_taken && (n_iss == pq.size());
    acc = exp_ready && ifc.ins_valid;
    chk("ins_ready", ifc.ins_ready, exp_ready);
    if (ifc.ins_ready !== 1'b1) ready_low++;
    e_ope = NOP_E; e_opo = NOP_O; has_e = 0; has_o = 0;
    {e_rae, e_rbe, e_rce, e_rte, e_rao, e_rbo, e_rco, e_rto} = '0;
    e_imme = '0; e_immo = '0; uid_e = '0; uid_o = '0; e_pc = '0;
    for (int k = 0; k < n_iss; k++) begin
      x = pq[k].i;
      if (x.pipe == 0) begin
        has_e = 1; e_ope = x.opc[10:0]; uid_e = x.uid[2:0];
        e_rae = x.ra[6:0]; e_rbe = x.rb[6:0]; e_rce = x.rc[6:0]; e_rte = x.rt[6:0];
        e_imme = x.imm[17:0];
      end else begin
        has_o = 1; e_opo = x.opc[10:0]; uid_o = x.uid[2:0]; e_pc = pq[k].pc;
        e_rao = x.ra[6:0]; e_rbo = x.rb[6:0]; e_rco = x.rc[6:0]; e_rto = x.rt[6:0];
        e_immo = x.imm[17:0];
      end
    end
    e_uid   = has_e ? uid_e : (has_o ? uid_o : 3'd0);
    e_stall = (pq.size() > 0) && (n_iss == 0);
    e_rv    = branch_taken;
    e_rpc   = PC_out;
    @(posedge clk);
    #1;
    chk("opcode_even", rf_opcode_even, e_ope);
    chk("opcode_odd", rf_opcode_odd, e_opo);
    chk("ra_even", ra_e, e_rae);  chk("rb_even", rb_e, e_rbe);
    chk("rc_even", rc_e, e_rce);  chk("rt_even", rt_e, e_rte);
    chk("ra_odd", ra_o, e_rao);   chk("rb_odd", rb_o, e_rbo);
    chk("rc_odd", rc_o, e_rco);   chk("rt_odd", rt_o, e_rto);
    chk("imm7_even", imm7_e, e_imme[6:0]);
    chk("imm10_even", imm10_e, e_imme[9:0]);
    chk("imm7_odd", imm7_o, e_immo[6:0]);
    chk("imm10_odd", imm10_o, e_immo[9:0]);
    chk("imm16_odd", imm16_o, e_immo[15:0]);
    chk("imm18_odd", imm18_o, e_immo);
    chk("unit_id", rf_unit_id, e_uid);
    chk("stall", stall, e_stall);
    chk("redirect_valid", redirect_valid, e_rv);
    if (e_rv) chk("redirect_pc", redirect_pc, e_rpc);
    if (has_o) chk("odd_pc", PC, e_pc);
    if (stall === 1'b1) stall_cnt++;
    for (int r = 0; r < 128; r++) if (sb[r] > 0) sb[r]--;
    for (int k = 0; k < n_iss; k++) if (pq[k].i.wr != 0) sb[pq[k].i.rt] = pq[k].i.lat;
    if (branch_taken) pq.delete();
    else for (int k = 0; k < n_iss; k++) void'(pq.pop_front());
    if (acc) begin
      p.i = cur_a; p.pc = cur_pc; pq.push_back(p);
      if (cur_v1) begin p.i = cur_b; p.pc = cur_pc + 32'd4; pq.push_back(p); end
    end
    last_acc = acc;
  endtask

  task automatic load(ins_t a, ins_t b, logic v1, logic [31:0] pc);
    cur_a = a; cur_b = b; cur_v1 = v1; cur_pc = pc;
    ifc.ins0_desc = enc(a); ifc.ins1_desc = enc(b);
    ifc.ins1_valid = v1; ifc.ins_pc = pc;
  endtask

  task automatic drive_pair(ins_t a, ins_t b, logic v1, logic [31:0] pc);
    int guard = 0;
    load(a, b, v1, pc);
    ifc.ins_valid = 1'b1;
    do begin
      cycle();
      guard++;
    end while (!last_acc && guard < 40);
    ifc.ins_valid = 1'b0;
    chk("accept_in_time", last_acc, 1);
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic chk_reset_outputs();
    chk("rst_opcode_even", rf_opcode_even, NOP_E);
    chk("rst_opcode_odd", rf_opcode_odd, NOP_O);
    chk("rst_addrs", {ra_e, rb_e, rc_e, rt_e, ra_o, rb_o, rc_o, rt_o}, 0);
    chk("rst_imms", {imm10_e, imm18_o}, 0);
    chk("rst_unit_id", rf_unit_id, 0);
    chk("rst_pc", PC, 0);
    chk("rst_stall", stall, 0);
    chk("rst_redirect", {redirect_valid, redirect_pc}, 0);
    chk("rst_ins_ready", ifc.ins_ready, 1);
  endtask

  initial begin
    ins_t a, b;
    reset = 1'b1; branch_taken = 1'b0; PC_out = '0;
    ifc.ins_valid = 1'b0; ifc.ins1_valid = 1'b0; ifc.ins_pc = '0;
    ifc.ins0_desc = '0; ifc.ins1_desc = '0;
    ready_low = 0; stall_cnt = 0; last_acc = 0;
    for (int r = 0; r < 128; r++) sb[r] = 0;
    #3;
    chk_reset_outputs();
    @(posedge clk); #1;
    reset = 1'b0;

    // Independent even/odd pair dual-issues; ready never drops.
    ready_low = 0;
    drive_pair(mk(0, 1, 2, 5, 0, 0), mk(1, 1, 3, 6, 0, 0), 1'b1, 32'h100);
    idle(3);
    chk("indep_ready_low_cycles", ready_low, 0);

    // Two evens split; a following pair sees ready low for exactly one cycle.
    drive_pair(mk(0, 1, 2, 20, 0, 0), mk(0, 1, 2, 21, 0, 0), 1'b1, 32'h140);
    ready_low = 0;
    drive_pair(mk(0, 0, 2, 22, 0, 0), mk(1, 0, 2, 23, 0, 0), 1'b1, 32'h180);
    chk("two_even_ready_low_cycles", ready_low, 1);
    idle(4);

    // RAW on r10 with latency 6, reader presented after the writer issues.
    drive_pair(mk(0, 1, 6, 10, 0, 0), mk(1, 0, 2, 11, 0, 0), 1'b0, 32'h1c0);
    cycle();
    stall_cnt = 0;
    drive_pair(mk(1, 0, 2, 12, 1, 10), mk(0, 0, 2, 13, 0, 0), 1'b0, 32'h1d0);
    idle(8);
    chk("raw_stall_cycles", stall_cnt, 5);

    // Slot 1 reads slot 0's destination.
    drive_pair(mk(0, 1, 4, 30, 0, 0), mk(1, 0, 2, 31, 1, 30), 1'b1, 32'h1e0);
    idle(8);

    // Branch while only slot 1 is pending; a pair offered that cycle is refused.
    drive_pair(mk(0, 1, 2, 40, 0, 0), mk(0, 1, 2, 41, 0, 0), 1'b1, 32'h240);
    cycle();
    load(mk(0, 0, 2, 42, 0, 0), mk(1, 0, 2, 43, 0, 0), 1'b1, 32'h280);
    ifc.ins_valid = 1'b1; branch_taken = 1'b1; PC_out = 32'h200;
    cycle();
    branch_taken = 1'b0; PC_out = '0;
    chk("branch_redirect_pc", redirect_pc, 32'h200);
    drive_pair(cur_a, cur_b, 1'b1, 32'h280);
    idle(4);

    // Randomized traffic with occasional redirects.
    for (int n = 0; n < 800; n++) begin
      if (!ifc.ins_valid && $urandom_range(0, 3) != 0) begin
        a = rnd_ins(); b = rnd_ins();
        load(a, b, 1'($urandom_range(0, 1)), $urandom() & 32'hFFFF_FFFC);
        ifc.ins_valid = 1'b1;
      end
      branch_taken = ($urandom_range(0, 15) == 0);
      PC_out = $urandom() & 32'hFFFF_FFFC;
      cycle();
      if (last_acc) ifc.ins_valid = 1'b0;
    end
    branch_taken = 1'b0; ifc.ins_valid = 1'b0;
    idle(10);

    // Reset while a stalled pair fills the buffer.
    drive_pair(mk(0, 1, 7, 50, 0, 0), mk(1, 0, 2, 51, 0, 0), 1'b0, 32'h300);
    drive_pair(mk(1, 0, 2, 52, 1, 50), mk(0, 0, 2, 53, 0, 0), 1'b1, 32'h310);
    cycle();
    #2;
    reset = 1'b1;
    #1;
    chk_reset_outputs();
    pq.delete();
    for (int r = 0; r < 128; r++) sb[r] = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    drive_pair(mk(0, 1, 3, 60, 1, 50), mk(1, 1, 3, 61, 0, 0), 1'b1, 32'h400);
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
